// File: rtl/debouncer_bank_pkg.sv
// ----------------------------------------------------------------------------
// debouncer_bank_pkg
// Shared definitions for the keypad input-encoder blocks: default channel
// count, default stability window, the per-channel counter width helper and
// the edge-event encoding used inside each debouncer channel.
// ----------------------------------------------------------------------------
package debouncer_bank_pkg;

    localparam int DEF_CHANNELS      = 10;
    localparam int DEF_STABLE_CYCLES = 4;

    // Edge event produced by a channel on the edge where its state flips.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    // Counter width able to hold 0..stable_cycles; never narrower than 1 bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// ----------------------------------------------------------------------------
// debouncer_channel
// One debounced input: two-flop synchroniser, disagreement counter,
// debounced state bit and one-cycle rise/fall pulses.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   tick      sample enable; counter and state only move on tick cycles
//   raw_in    asynchronous bouncy level
//   state     registered debounced level
//   rise      one-cycle pulse after state goes 0->1
//   fall      one-cycle pulse after state goes 1->0
//   rise_nxt  combinational value that rise takes on the next edge, so the
//             bank can register its OR-reduction in the same cycle as rise
// ----------------------------------------------------------------------------
module debouncer_channel
    import debouncer_bank_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_in,
    output logic state,
    output logic rise,
    output logic fall,
    output logic rise_nxt
);

    localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             state_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;

    logic             differ_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    edge_e            edge_s;

    // Next counter value and edge event; the counter is cleared whenever the
    // synchronised input agrees with state, so a bounce restarts the window.
    always_comb begin
        differ_s  = sync2_r ^ state_r;
        cnt_nxt_s = cnt_r;
        edge_s    = EDGE_NONE;
        if (tick) begin
            if (differ_s) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s = '0;
                    edge_s    = state_r ? EDGE_FALL : EDGE_RISE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_nxt_s = '0;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Two-flop synchroniser, clocked every cycle regardless of tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
        end else begin
            sync1_r <= raw_in;
            sync2_r <= sync1_r;
        end
    end

    // Counter, debounced state and edge pulses update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            state_r <= RESET_VAL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            case (edge_s)
                EDGE_RISE: begin
                    state_r <= 1'b1;
                    rise_r  <= 1'b1;
                    fall_r  <= 1'b0;
                end
                EDGE_FALL: begin
                    state_r <= 1'b0;
                    rise_r  <= 1'b0;
                    fall_r  <= 1'b1;
                end
                default: begin
                    state_r <= state_r;
                    rise_r  <= 1'b0;
                    fall_r  <= 1'b0;
                end
            endcase
        end
    end

    assign state    = state_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign rise_nxt = (edge_s == EDGE_RISE);

endmodule

// File: rtl/debouncer_bank.sv
// ----------------------------------------------------------------------------
// debouncer_bank
// CHANNELS independent keypad debouncers sharing one clock, reset and tick.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   tick      sample enable (prescaler strobe); tie high for per-clock use
//   raw_in    CHANNELS asynchronous bouncy levels
//   state     CHANNELS registered debounced levels
//   rise      CHANNELS one-cycle 0->1 pulses
//   fall      CHANNELS one-cycle 1->0 pulses
//   any_rise  OR of rise, registered alongside rise
// ----------------------------------------------------------------------------
module debouncer_bank
    import debouncer_bank_pkg::*;
#(
    parameter int   CHANNELS      = DEF_CHANNELS,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_rise
);

    logic [CHANNELS-1:0] rise_nxt_s;
    logic                any_rise_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debouncer_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .raw_in   (raw_in[g]),
            .state    (state[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .rise_nxt (rise_nxt_s[g])
        );
    end

    // Reduce the channels' next-rise values so any_rise lines up with rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_rise_r <= 1'b0;
        end else begin
            any_rise_r <= |rise_nxt_s;
        end
    end

    assign any_rise = any_rise_r;

endmodule

// File: doc/debouncer_bank.md
DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 Parameter CHANNELS, default 10, SHALL set the number of independent raw inputs debounced (keypad keys).
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive qualifying ticks of disagreement needed before a channel's debounced state changes; legal range 1..65535.
REQ-003 Parameter RESET_VAL, default 1'b0, SHALL set the reset level of every synchroniser stage and every debounced state bit.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 tick  input  1  SHALL be the sample enable (prescaler strobe); tie high for per-clock debouncing.
REQ-007 raw_in  input  CHANNELS  SHALL carry the asynchronous, bouncy switch levels.
REQ-008 state  output  CHANNELS  SHALL carry the registered debounced level per channel.
REQ-009 rise  output  CHANNELS  SHALL pulse high one clk cycle when the matching state bit goes 0->1.
REQ-010 fall  output  CHANNELS  SHALL pulse high one clk cycle when the matching state bit goes 1->0.
REQ-011 any_rise  output  1  SHALL equal the OR of all rise bits, registered together with rise (no extra latency).

Function
REQ-012 Each raw_in bit SHALL pass through a two-flop synchroniser clocked every clk, independent of tick.
REQ-013 Per channel, a counter of width clog2(STABLE_CYCLES+1) SHALL increment on each tick cycle where synchronised input differs from state, and SHALL clear on any tick cycle where they agree.
REQ-014 When a tick cycle sees disagreement with the counter at STABLE_CYCLES-1, the channel SHALL, on that edge, invert state, clear the counter, and assert rise or fall for exactly that following cycle.
REQ-015 Cycles with tick low SHALL hold counters and state unchanged; rise/fall/any_rise SHALL be 0 in the cycle after any non-qualifying edge.
REQ-016 Latency with tick tied high: a raw level first sampled at edge E and held SHALL appear on state at edge E+STABLE_CYCLES+1; rise/fall valid in the same cycle.
REQ-017 A disagreement lasting fewer than STABLE_CYCLES consecutive tick cycles (glitch/bounce) SHALL leave state unchanged and produce no pulse.
REQ-018 Counter SHALL never exceed STABLE_CYCLES-1 nor wrap; state and counter update in the same edge.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-020 rise and fall of one channel SHALL never be high in the same cycle.

Reset
REQ-021 rst_n low SHALL immediately set synchroniser stages and state to RESET_VAL, counters to 0, rise/fall/any_rise to 0, regardless of clk or tick.
REQ-022 Reset deassertion SHALL produce no rise/fall pulse even if raw_in differs from RESET_VAL; such a difference SHALL be debounced normally per REQ-016.
REQ-023 Reset asserted mid-count SHALL discard partial counts; no pulse SHALL be emitted for the aborted transition.

Structure
REQ-024 A shared include file debouncer_defs.vh SHALL hold default STABLE_CYCLES, default CHANNELS and the counter-width function used by all input-encoder blocks.
REQ-025 One sub-module, debouncer_channel (synchroniser, counter, state, rise/fall for one bit), SHALL be instantiated CHANNELS times via generate; any_rise reduction lives in debouncer_bank.

Verification
REQ-026 Reset release with raw_in=0, STABLE_CYCLES=4, tick=1: state=0, no pulses; raw_in[0]->1 sampled at edge 0 -> state[0]=1 and rise[0]=any_rise=1 after edge 5, both 0 after edge 6.
REQ-027 Bounce: raw_in[3] toggles 1,0,1,0 each cycle then holds 1 -> state[3] rises exactly once, 4 tick cycles after last toggle reaches synchroniser; fall[3] never asserts.
REQ-028 tick high every 3rd clk, STABLE_CYCLES=4: held change SHALL take 4 tick pulses after synchronisation; 3-tick glitch produces no change.
REQ-029 raw_in[1] and raw_in[7] set to 1 on same edge -> rise[1], rise[7] same cycle, any_rise single cycle high; later both cleared -> fall pulses same cycle, any_rise stays 0.
REQ-030 rst_n pulsed low mid-clock after 2 of 4 counts -> outputs cleared asynchronously, no pulse; post-release held input debounces from zero count (full 4+2 edges).
REQ-031 STABLE_CYCLES=1, RESET_VAL=1: raw_in=0 held -> state falls at edge E+2 with fall pulse; counter width 1 without overflow.
